// File: rtl/cam_capture_ctrl.sv
// -----------------------------------------------------------------------------
// cam_capture_ctrl
//   OV7670 capture controller. The camera bus (PCLK/VSYNC/HREF/D) is sampled
//   in the system clock domain through SYNC_STAGES-deep synchronisers. Pairs of
//   bytes are assembled into RGB565 pixels, converted to the selected output
//   format and written as a linear frame-buffer image into a DP RAM write port.
//   Supports single-shot and continuous capture, clipping to the stored frame
//   size and a frame-done pulse.
//
//   Optional build macro: CAM_DECIM2_EN
//     defined   : 2:1 decimation, only even pixels of even source lines kept
//     undefined : every pixel stored, subject to clipping
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   PCLK, VSYNC, HREF camera timing (asynchronous, sampled)
//   D[7:0]            camera data byte
//   mode[1:0]         00 RGB332, 01 RGB444 (DW=12 only), 10 gray8, 11 = 00
//   cap_single        one-cycle request to capture one frame
//   cap_cont          level request for back-to-back frames
//   addr[AW-1:0]      RAM write address
//   data[DW-1:0]      RAM write data
//   regwrite          RAM write strobe (1-cycle pulse)
//   busy              high while waiting for / capturing a frame
//   frame_done        1-cycle pulse at the end of a captured frame
// -----------------------------------------------------------------------------
module cam_capture_ctrl #(
  parameter int CAM_SCREEN_X = 320,
  parameter int CAM_SCREEN_Y = 240,
  parameter int AW           = 17,
  parameter int DW           = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PCLK,
  input  logic          VSYNC,
  input  logic          HREF,
  input  logic [7:0]    D,
  input  logic [1:0]    mode,
  input  logic          cap_single,
  input  logic          cap_cont,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          regwrite,
  output logic          busy,
  output logic          frame_done
);

`ifdef CAM_DECIM2_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif

  // Counters run in source coordinates; with decimation the source is twice
  // the stored size, so the saturation limits scale with SH.
  localparam int XMAX = CAM_SCREEN_X << SH;
  localparam int YMAX = CAM_SCREEN_Y << SH;
  localparam int XW   = $clog2(XMAX + 1);
  localparam int YW   = $clog2(YMAX + 1);
  localparam logic [XW-1:0] XLIM = XW'(XMAX);
  localparam logic [YW-1:0] YLIM = YW'(YMAX);
  localparam logic [AW-1:0] XDIM = AW'(CAM_SCREEN_X);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_CAPTURE, S_DONE} state_t;
  state_t state_q, state_d;

  // synchronisers
  logic [SYNC_STAGES-1:0]      pclk_sync_q, vs_sync_q, href_sync_q;
  logic [SYNC_STAGES-1:0][7:0] d_sync_q;
  logic                        pclk_prev_q, vs_prev_q, href_prev_q;
  logic                        pclk_s, vs_s, href_s;
  logic [7:0]                  d_s;

  assign pclk_s = pclk_sync_q[SYNC_STAGES-1];
  assign vs_s   = vs_sync_q[SYNC_STAGES-1];
  assign href_s = href_sync_q[SYNC_STAGES-1];
  assign d_s    = d_sync_q[SYNC_STAGES-1];

  logic pclk_rise, vs_fall, vs_rise;
  assign pclk_rise = pclk_s & ~pclk_prev_q;
  assign vs_fall   = vs_prev_q & ~vs_s;
  assign vs_rise   = ~vs_prev_q & vs_s;

  // datapath state
  logic [1:0]    mode_q;
  logic [7:0]    hi_q;
  logic          phase_q;
  logic          line_pix_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          regwrite_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (cap_single || cap_cont) state_d = S_WAIT_VS;
      S_WAIT_VS: if (vs_fall)                state_d = S_CAPTURE;
      S_CAPTURE: if (vs_rise)                state_d = S_DONE;
      S_DONE:    state_d = cap_cont ? S_WAIT_VS : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pixel control
  // ---------------------------------------------------------------------------
  logic frame_start, in_cap, byte_en, href_fall, pix_done, keep, store;

  assign frame_start = (state_q == S_WAIT_VS) && vs_fall;
  // Bytes arriving in the VSYNC-rise cycle are dropped so the last write can
  // never coincide with the DONE cycle.
  assign in_cap      = (state_q == S_CAPTURE) && !vs_rise;
  assign byte_en     = in_cap && pclk_rise && href_s;
  assign href_fall   = in_cap && href_prev_q && !href_s;
  assign pix_done    = byte_en && phase_q;

`ifdef CAM_DECIM2_EN
  assign keep = ~x_q[0] & ~y_q[0];
`else
  assign keep = 1'b1;
`endif

  assign store = pix_done && keep && (x_q < XLIM) && (y_q < YLIM);

  logic [AW-1:0] addr_d;
  assign addr_d = AW'(y_q >> SH) * XDIM + AW'(x_q >> SH);

  // ---------------------------------------------------------------------------
  // Format conversion: hi = {R4..R0,G5..G3}, lo (current byte) = {G2..G0,B4..B0}
  // ---------------------------------------------------------------------------
  logic [4:0]    r_c, b_c;
  logic [5:0]    g_c, s_c;
  logic [7:0]    gsum_c, gray_c, rgb332_c;
  logic [11:0]   rgb444_c;
  logic [DW-1:0] data_d;

  always_comb begin
    r_c      = hi_q[7:3];
    g_c      = {hi_q[2:0], d_s[7:5]};
    b_c      = d_s[4:0];
    gsum_c   = {2'b00, r_c, 1'b0} + {1'b0, g_c, 1'b0} + {2'b00, b_c, 1'b0};
    s_c      = 6'(gsum_c >> 2);
    gray_c   = {s_c, s_c[5:4]};
    rgb332_c = {hi_q[7:5], hi_q[2:0], d_s[4:3]};
    rgb444_c = {hi_q[7:4], hi_q[2:0], d_s[7], d_s[4:1]};
    data_d   = DW'(rgb332_c);
    if (mode_q == 2'b10)                 data_d = DW'(gray_c);
    else if (mode_q == 2'b01 && DW == 12) data_d = DW'(rgb444_c);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_sync_q <= '0;
      vs_sync_q   <= '0;
      href_sync_q <= '0;
      d_sync_q    <= '0;
      pclk_prev_q <= 1'b0;
      vs_prev_q   <= 1'b0;
      href_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      mode_q      <= 2'b00;
      hi_q        <= 8'h00;
      phase_q     <= 1'b0;
      line_pix_q  <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      regwrite_q  <= 1'b0;
    end else begin
      pclk_sync_q <= {pclk_sync_q[SYNC_STAGES-2:0], PCLK};
      vs_sync_q   <= {vs_sync_q[SYNC_STAGES-2:0], VSYNC};
      href_sync_q <= {href_sync_q[SYNC_STAGES-2:0], HREF};
      d_sync_q    <= {d_sync_q[SYNC_STAGES-2:0], D};
      pclk_prev_q <= pclk_s;
      vs_prev_q   <= vs_s;
      href_prev_q <= href_s;
      state_q     <= state_d;

      regwrite_q  <= store;
      if (store) begin
        addr_q <= addr_d;
        data_q <= data_d;
      end

      if (frame_start) begin
        mode_q     <= mode;
        phase_q    <= 1'b0;
        line_pix_q <= 1'b0;
        x_q        <= '0;
        y_q        <= '0;
      end else if (href_fall) begin
        // an odd trailing byte is discarded by forcing the phase back to 0
        phase_q    <= 1'b0;
        line_pix_q <= 1'b0;
        x_q        <= '0;
        if (line_pix_q && (y_q < YLIM)) y_q <= y_q + YW'(1);
      end else if (byte_en) begin
        phase_q <= ~phase_q;
        if (!phase_q) begin
          hi_q <= d_s;
        end else begin
          line_pix_q <= 1'b1;
          if (x_q < XLIM) x_q <= x_q + XW'(1);
        end
      end
    end
  end

  assign addr       = addr_q;
  assign data       = data_q;
  assign regwrite   = regwrite_q;
  assign busy       = (state_q == S_WAIT_VS) || (state_q == S_CAPTURE);
  assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cam_capture_ctrl
//   Drives camera frames (randomised sizes, bytes, modes) into cam_capture_ctrl
//   and compares every RAM write against a write list computed from the frame
//   contents with plain arithmetic. Directed frames pin the model with literals.
// -----------------------------------------------------------------------------
module tb_cam_capture_ctrl;
  localparam int SX = 6;
  localparam int SY = 4;
  localparam int AW = 17;
  localparam int DW = 12;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst, PCLK, VSYNC, HREF, cap_single, cap_cont;
  logic [7:0]    D;
  logic [1:0]    mode;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          regwrite, busy, frame_done;

  cam_capture_ctrl #(
    .CAM_SCREEN_X(SX), .CAM_SCREEN_Y(SY), .AW(AW), .DW(DW), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst(rst), .PCLK(PCLK), .VSYNC(VSYNC), .HREF(HREF), .D(D),
    .mode(mode), .cap_single(cap_single), .cap_cont(cap_cont),
    .addr(addr), .data(data), .regwrite(regwrite), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  typedef struct { int a; int d; } wr_t;
  wr_t exp_q[$];
  wr_t obs_q[$];
  int  fd_cnt    = 0;
  bit  quiet     = 1'b0;
  bit  mon_busy  = 1'b0;
  int  busy_drop = 0;

  // current frame: nl lines, nb[l] bytes per line
  int         nl;
  int         nb[8];
  logic [7:0] fb[8][24];

  // Output format from the pixel's colour components.
  function automatic int fmt(input int hi, input int lo, input int m);
    int r, g, b, s;
    r = hi >> 3;
    g = ((hi & 7) << 3) | (lo >> 5);
    b = lo & 31;
    if (m == 2) begin
      s = (r + g + b) >> 1;               // = (2R + 2G + 2B) / 4
      return ((s << 2) | (s >> 4)) & 255;
    end
    if (m == 1 && DW == 12) return ((r >> 1) << 8) | ((g >> 2) << 4) | (b >> 1);
    return ((r >> 2) << 5) | ((g >> 3) << 2) | (b >> 3);
  endfunction

  // Expected writes for the current frame; pixels from (cut_l, cut_p) on are
  // not produced.
  task automatic model_frame(input int m, input int cut_l, input int cut_p);
    int y, npix;
    y = 0;
    for (int l = 0; l < nl; l++) begin
      npix = nb[l] / 2;
      for (int p = 0; p < npix; p++) begin
        if (l > cut_l || (l == cut_l && p >= cut_p)) return;
`ifdef CAM_DECIM2_EN
        if (p % 2 == 0 && y % 2 == 0 && p / 2 < SX && y / 2 < SY)
          exp_q.push_back('{(y / 2) * SX + p / 2, fmt(fb[l][2*p], fb[l][2*p+1], m)});
`else
        if (p < SX && y < SY)
          exp_q.push_back('{y * SX + p, fmt(fb[l][2*p], fb[l][2*p+1], m)});
`endif
      end
      if (npix > 0) y++;
    end
  endtask

  task automatic gen_frame(input int max_l);
    int npx;
    nl = $urandom_range(1, max_l);
    for (int l = 0; l < nl; l++) begin
      npx   = $urandom_range(0, 9);
      nb[l] = 2 * npx + (($urandom_range(0, 3) == 0) ? 1 : 0);
      if (nb[l] == 0) nb[l] = 1;
      for (int k = 0; k < nb[l]; k++) fb[l][k] = 8'($urandom);
    end
  endtask

  task automatic pulse_single();
    @(negedge clk); cap_single = 1'b1;
    @(negedge clk); cap_single = 1'b0;
  endtask

  // Camera timing is driven 2 ns after a falling clk edge and kept on a
  // 40 ns grid, so no camera edge lands on an active clk edge.
  task automatic drive_frame(input int rst_l, input int rst_p, input bit drop_cont);
    @(negedge clk); #2;
    VSYNC = 1'b1; #160;
    VSYNC = 1'b0; #160;
    if (drop_cont) begin cap_cont = 1'b0; mon_busy = 1'b0; end
    mode = mode ^ 2'($urandom_range(1, 3));   // latched mode must not follow this
    for (int l = 0; l < nl; l++) begin
      HREF = 1'b1;
      for (int k = 0; k < nb[l]; k++) begin
        if (l == rst_l && k == 2 * rst_p) begin
          #40;
          quiet = 1'b1; rst = 1'b1;
          #10;
          chk("rst_mid_regwrite", int'(regwrite), 0);
          chk("rst_mid_addr", int'(addr), 0);
          chk("rst_mid_data", int'(data), 0);
          chk("rst_mid_busy", int'(busy), 0);
          #10; rst = 1'b0;
          cap_single = 1'b1; #10; cap_single = 1'b0;
        end
        D = fb[l][k];
        #40 PCLK = 1'b1;
        #40 PCLK = 1'b0;
      end
      HREF = 1'b0; #160;
    end
    VSYNC = 1'b1; #160;
  endtask

  // compare process
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (regwrite || frame_done) chk("wr_fd_overlap", int'(regwrite & frame_done), 0);
      if (frame_done) fd_cnt++;
      if (mon_busy && !busy && !frame_done) busy_drop++;
      if (quiet) chk("quiet_write", int'(regwrite), 0);
      else if (regwrite) begin
        obs_q.push_back('{int'(addr), int'(data)});
        chk("exp_available", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(addr), e.a);
          chk("wr_data", int'(data), e.d);
        end
      end
    end
  end

  task automatic settle_and_check(input string tag, input int fd0, input int fd_exp);
    repeat (10) @(negedge clk);
    chk({tag, "_exp_drained"}, exp_q.size(), 0);
    chk({tag, "_frame_done"}, fd_cnt - fd0, fd_exp);
    chk({tag, "_busy_idle"}, int'(busy), 0);
  endtask

  initial begin
    int fd0;
    rst = 1'b1; PCLK = 1'b0; VSYNC = 1'b1; HREF = 1'b0; D = 8'h00;
    mode = 2'b00; cap_single = 1'b0; cap_cont = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_addr", int'(addr), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_regwrite", int'(regwrite), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    rst = 1'b0;

    // model pins
    chk("pin_red332", fmt('hF8, 'h00, 0), 'hE0);
    chk("pin_gray_white", fmt('hFF, 'hFF, 2), 'hFB);
    chk("pin_gray_blue", fmt('h00, 'h1F, 2), 'h3C);
    chk("pin_gray_green", fmt('h07, 'hE0, 2), 'h7D);
    chk("pin_rgb444_white", fmt('hFF, 'hFF, 1), 'hFFF);
    chk("pin_mode3_as_332", fmt('hF8, 'h00, 3), 'hE0);

    // 4x3 red frame, single shot
    nl = 3;
    for (int l = 0; l < 3; l++) begin
      nb[l] = 8;
      for (int k = 0; k < 8; k++) fb[l][k] = (k % 2 == 0) ? 8'hF8 : 8'h00;
    end
    mode = 2'b00; obs_q.delete(); fd0 = fd_cnt;
    pulse_single();
    @(negedge clk);
    chk("t1_busy_wait", int'(busy), 1);
    model_frame(int'(mode), 99, 0);
    drive_frame(99, 0, 1'b0);
    settle_and_check("t1", fd0, 1);
`ifndef CAM_DECIM2_EN
    chk("t1_nwrites", obs_q.size(), 12);
    if (obs_q.size() == 12) begin
      chk("t1_addr5", obs_q[5].a, 7);
      chk("t1_addr11", obs_q[11].a, 15);
      chk("t1_data11", obs_q[11].d, 'hE0);
    end
`endif

    // gray pixels
    nl = 1; nb[0] = 6;
    fb[0][0] = 8'hFF; fb[0][1] = 8'hFF; fb[0][2] = 8'h00;
    fb[0][3] = 8'h1F; fb[0][4] = 8'h07; fb[0][5] = 8'hE0;
    mode = 2'b10; obs_q.delete(); fd0 = fd_cnt;
    pulse_single();
    model_frame(int'(mode), 99, 0);
    drive_frame(99, 0, 1'b0);
    settle_and_check("t2", fd0, 1);
`ifndef CAM_DECIM2_EN
    chk("t2_nwrites", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("t2_gray_white", obs_q[0].d, 'hFB);
      chk("t2_gray_blue", obs_q[1].d, 'h3C);
      chk("t2_gray_green", obs_q[2].d, 'h7D);
    end
`endif

    // clipping: 8-pixel line into a 6-wide frame, then a 1-pixel + odd byte line
    nl = 2; nb[0] = 16; nb[1] = 3;
    for (int k = 0; k < 16; k++) fb[0][k] = 8'($urandom);
    for (int k = 0; k < 3; k++) fb[1][k] = 8'($urandom);
    mode = 2'b00; obs_q.delete(); fd0 = fd_cnt;
    pulse_single();
    model_frame(int'(mode), 99, 0);
    drive_frame(99, 0, 1'b0);
    settle_and_check("t3", fd0, 1);
`ifndef CAM_DECIM2_EN
    chk("t3_nwrites", obs_q.size(), 7);
    if (obs_q.size() == 7) begin
      chk("t3_last_in_line", obs_q[5].a, 5);
      chk("t3_next_line", obs_q[6].a, 6);
    end
`endif

    // continuous capture over three frames
    fd0 = fd_cnt; busy_drop = 0;
    @(negedge clk); cap_cont = 1'b1;
    repeat (3) @(negedge clk);
    mon_busy = 1'b1;
    for (int f = 0; f < 3; f++) begin
      gen_frame(3);
      model_frame(int'(mode), 99, 0);
      drive_frame(99, 0, f == 2);
    end
    settle_and_check("t4", fd0, 3);
    chk("t4_busy_held", busy_drop, 0);

    // reset at pixel 5 of line 1, then re-arm mid-frame
    nl = 3;
    for (int l = 0; l < 3; l++) begin
      nb[l] = 16;
      for (int k = 0; k < 16; k++) fb[l][k] = 8'($urandom);
    end
    fd0 = fd_cnt;
    pulse_single();
    model_frame(int'(mode), 1, 5);
    drive_frame(1, 5, 1'b0);
    repeat (5) @(negedge clk);
    chk("t5_no_frame_done", fd_cnt - fd0, 0);
    chk("t5_exp_drained", exp_q.size(), 0);
    chk("t5_rearmed_busy", int'(busy), 1);
    quiet = 1'b0;
    gen_frame(4);
    fd0 = fd_cnt;
    model_frame(int'(mode), 99, 0);
    drive_frame(99, 0, 1'b0);
    settle_and_check("t5_next", fd0, 1);

    // randomised single-shot frames
    for (int it = 0; it < 10; it++) begin
      gen_frame(6);
      mode = 2'($urandom_range(0, 3));
      fd0 = fd_cnt;
      pulse_single();
      model_frame(int'(mode), 99, 0);
      drive_frame(99, 0, 1'b0);
      settle_and_check("rnd", fd0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
